hw_stack: RTL and testbench
===========================

Name: hw_stack

Overview:
- Synchronous LIFO that serves as the responder for the stack-processor core's push/pop interface.
- Accepts push/pop strobes, returns popped data the cycle after the pop strobe, and reports full/empty/occupancy.
- Latches sticky overflow/underflow errors so firmware and bench can detect misuse.
- Sits between the multicycle core and its operand storage; one instance per core.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 16, number of entries (power of two, >= 2)
AW, 4, pointer width = log2(DEPTH); count is AW+1 bits

Ports:
clk  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
push  input  1  write data_in onto top of stack this edge
pop  input  1  remove top entry this edge; value appears on data_out after the edge
clear  input  1  synchronous flush: empties stack and clears error flags
data_in  input  WIDTH  value to push
data_out  output  WIDTH  last popped value (registered)
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  AW+1  current number of stored entries
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (resetN low, asynchronous): sp=0, count=0, data_out=0, overflow=0, underflow=0, empty=1, full=0. Memory contents are don't-care.
- full, empty and count are combinational from the registered count; they never lag state.
- Priority each edge: clear > push/pop. With clear=1, push/pop are ignored, count=0, errors=0, data_out holds.
- Push only, not full: mem[sp] <= data_in; sp++, count++. data_out holds.
- Push only, full: no write, no pointer change; overflow <= 1.
- Pop only, not empty: data_out <= mem[sp-1]; sp--, count--. The popped value is valid the cycle after the strobe; the core samples it in the following state.
- Pop only, empty: data_out holds; underflow <= 1; sp/count unchanged.
- Push and pop together, not empty (replace-top):
  - data_out <= mem[sp-1] (old top).
  - mem[sp-1] <= data_in.
  - sp and count unchanged.
  - Legal when full; no overflow.
- Push and pop together, empty:
  - Push takes effect (mem[0] <= data_in, count=1).
  - underflow <= 1; data_out holds.
- Pop of an entry written on the immediately preceding edge returns the new value. Memory is flop-based, so there is no read-during-write hazard.
- Strobes are level-sampled every edge. Holding push high for N cycles performs N pushes. The initiator owns pulse width.
- Error flags are sticky until clear or reset.
- resetN asserted mid-sequence: immediate return to reset values. The next edge after deassertion behaves as on an empty stack.
- count never exceeds DEPTH and never wraps below 0. sp arithmetic is modulo DEPTH, but the guard conditions above prevent wrap.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop x3 -> data_out is 0x33, 0x22, 0x11 on the cycles after each pop; count goes 3 then 0; empty=1; no errors.
- Push DEPTH values 0x00..0x0F, then push 0xAA -> full=1 after 16th push; overflow=1; count=16; subsequent pops return 0x0F first (0xAA not stored).
- From empty, pop -> underflow=1, data_out unchanged (0), count=0. Assert clear one cycle -> underflow=0.
- With stack {0x05, 0x07} (top 0x07), assert push=1, pop=1, data_in=0x09 -> data_out=0x07, count stays 2. Next pop returns 0x09, then 0x05.
- Push 0x44 and 0x55, then assert resetN low asynchronously mid-cycle -> outputs return to reset values before the next edge: count=0, empty=1, data_out=0. After release, pop gives underflow=1.
- Fill to full, then simultaneous push=1/pop=1 with 0xEE -> no overflow, count=16, data_out = old top, and the next pop yields 0xEE.

Source files
------------

// File: rtl/hw_stack.sv
// rtl/hw_stack.sv - flop-based LIFO responder for the stack-processor push/pop interface
//
// Ports:
//   clk        rising-edge clock
//   resetN     asynchronous active-low reset
//   push       push data_in onto the top of stack this edge
//   pop        remove the top entry this edge; value appears on data_out after the edge
//   clear      synchronous flush of occupancy and error flags (data_out holds)
//   data_in    value to push
//   data_out   last popped value (registered)
//   full       count == DEPTH
//   empty      count == 0
//   count      number of stored entries
//   overflow   sticky: push attempted while full
//   underflow  sticky: pop attempted while empty
module hw_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] SP_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    sp_q, sp_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    sp_m1;
  logic             is_full;
  logic             is_empty;

  // Flags come straight from the registered count so they never lag state.
  assign is_full  = (count_q == CNT_FULL);
  assign is_empty = (count_q == '0);
  assign sp_m1    = sp_q - SP_ONE;

  always_comb begin
    sp_d    = sp_q;
    count_d = count_q;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = sp_q;
    if (clear) begin
      sp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            sp_d    = sp_q + SP_ONE;
            count_d = count_q + CNT_ONE;
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            dout_d  = mem_q[sp_m1];
            sp_d    = sp_m1;
            count_d = count_q - CNT_ONE;
          end
        end
        2'b11: begin
          if (is_empty) begin
            // Nothing to pop: the push still lands, the pop is flagged.
            wr_en   = 1'b1;
            sp_d    = sp_q + SP_ONE;
            count_d = count_q + CNT_ONE;
            unf_d   = 1'b1;
          end else begin
            // Replace-top: return the old top and overwrite it in place,
            // occupancy unchanged, so this is legal even when full.
            dout_d  = mem_q[sp_m1];
            wr_en   = 1'b1;
            wr_addr = sp_m1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage carries no reset; its contents are meaningless while count is 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sp_q    <= '0;
      count_q <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign data_out  = dout_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_hw_stack.sv
// tb/tb_hw_stack.sv - scoreboard bench for hw_stack
module tb_hw_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk;
  logic             resetN;
  logic             push;
  logic             pop;
  logic             clear;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  typedef struct {
    string    name;
    int       dout;
    int       cnt;
    bit       ovf;
    bit       unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   n_reset_checks;

  hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input string field, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, req);
    end
  endtask

  // Compare every observable output against one expected post-state.
  task automatic check_state(input exp_t e);
    check(e.name, "data_out",  int'(data_out),  e.dout);
    check(e.name, "count",     int'(count),     e.cnt);
    check(e.name, "full",      int'(full),      (e.cnt == DEPTH) ? 1 : 0);
    check(e.name, "empty",     int'(empty),     (e.cnt == 0) ? 1 : 0);
    check(e.name, "overflow",  int'(overflow),  int'(e.ovf));
    check(e.name, "underflow", int'(underflow), int'(e.unf));
  endtask

  // Monitor: one scoreboard entry is retired per edge that had stimulus queued.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check_state(exp_q.pop_front());
    end
  end

  // Asynchronous reset must take effect without waiting for a clock edge.
  always @(negedge resetN) begin
    exp_t r;
    #1;
    r.name = "async_reset";
    r.dout = 0;
    r.cnt  = 0;
    r.ovf  = 1'b0;
    r.unf  = 1'b0;
    check_state(r);
    n_reset_checks++;
  end

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic cyc(input string name, input bit p, input bit q, input bit c,
                     input int din, input int e_dout, input int e_cnt,
                     input bit e_ovf, input bit e_unf);
    exp_t e;
    @(negedge clk);
    push    = p;
    pop     = q;
    clear   = c;
    data_in = WIDTH'(din);
    e.name = name;
    e.dout = e_dout;
    e.cnt  = e_cnt;
    e.ovf  = e_ovf;
    e.unf  = e_unf;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    data_in = '0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    n_reset_checks = 0;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    data_in = '0;
    resetN  = 1'b1;
    #3 resetN = 1'b0;
    #20 resetN = 1'b1;

    cyc("reset_idle", 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);

    // Underflow from empty, sticky across an idle cycle, cleared by clear.
    cyc("pop_empty",  0, 1, 0, 8'h00, 8'h00, 0, 0, 1);
    cyc("unf_sticky", 0, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    cyc("clear_unf",  0, 0, 1, 8'h00, 8'h00, 0, 0, 0);

    // LIFO order.
    cyc("push_11", 1, 0, 0, 8'h11, 8'h00, 1, 0, 0);
    cyc("push_22", 1, 0, 0, 8'h22, 8'h00, 2, 0, 0);
    cyc("push_33", 1, 0, 0, 8'h33, 8'h00, 3, 0, 0);
    cyc("pop_33",  0, 1, 0, 8'h00, 8'h33, 2, 0, 0);
    cyc("pop_22",  0, 1, 0, 8'h00, 8'h22, 1, 0, 0);
    cyc("pop_11",  0, 1, 0, 8'h00, 8'h11, 0, 0, 0);

    // Fill to full, then overflow; 0xAA must not be stored.
    for (int i = 0; i < DEPTH; i++) begin
      cyc("fill", 1, 0, 0, i, 8'h11, i + 1, 0, 0);
    end
    cyc("push_full",  1, 0, 0, 8'hAA, 8'h11, 16, 1, 0);
    cyc("pop_0f",     0, 1, 0, 8'h00, 8'h0F, 15, 1, 0);
    cyc("pop_0e",     0, 1, 0, 8'h00, 8'h0E, 14, 1, 0);
    cyc("clear_ovf",  0, 0, 1, 8'h00, 8'h0E, 0, 0, 0);

    // Replace-top on a two-entry stack.
    cyc("push_05",  1, 0, 0, 8'h05, 8'h0E, 1, 0, 0);
    cyc("push_07",  1, 0, 0, 8'h07, 8'h0E, 2, 0, 0);
    cyc("repl_09",  1, 1, 0, 8'h09, 8'h07, 2, 0, 0);
    cyc("pop_09",   0, 1, 0, 8'h00, 8'h09, 1, 0, 0);
    cyc("pop_05",   0, 1, 0, 8'h00, 8'h05, 0, 0, 0);

    // Push+pop on empty: push lands, underflow flagged, data_out holds.
    cyc("pp_empty", 1, 1, 0, 8'h66, 8'h05, 1, 0, 1);
    cyc("pop_66",   0, 1, 0, 8'h00, 8'h66, 0, 0, 1);
    cyc("clear2",   0, 0, 1, 8'h00, 8'h66, 0, 0, 0);

    // Clear has priority over a push in the same cycle.
    cyc("clr_push", 1, 0, 1, 8'h77, 8'h66, 0, 0, 0);

    // Mid-cycle asynchronous reset.
    cyc("push_44",  1, 0, 0, 8'h44, 8'h66, 1, 0, 0);
    cyc("push_55",  1, 0, 0, 8'h55, 8'h66, 2, 0, 0);
    idle();
    drain();
    @(posedge clk);
    #2 resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    cyc("pop_after_rst", 0, 1, 0, 8'h00, 8'h00, 0, 0, 1);
    cyc("clear3",        0, 0, 1, 8'h00, 8'h00, 0, 0, 0);

    // Replace-top while full: no overflow, occupancy held.
    for (int i = 0; i < DEPTH; i++) begin
      cyc("fill2", 1, 0, 0, 8'h30 + i, 8'h00, i + 1, 0, 0);
    end
    cyc("repl_full", 1, 1, 0, 8'hEE, 8'h3F, 16, 0, 0);
    cyc("pop_ee",    0, 1, 0, 8'h00, 8'hEE, 15, 0, 0);
    cyc("pop_3e",    0, 1, 0, 8'h00, 8'h3E, 14, 0, 0);

    idle();
    drain();
    n_checks++;
    if (n_reset_checks != 2) begin
      n_fail++;
      $display("FAIL reset_events: got %0d, expected 2", n_reset_checks);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
